seq_det_moore_param: RTL and testbench

//  Parametrised Moore serial pattern detector; successor to the fixed 0011 detector.
//  - Pattern length N; pattern runtime-loadable; overlap mode selectable; sample-enable gated.
//  - Counts matches in a saturating counter.
//  - Sits on a 1-bit serial stream; z and match_cnt feed downstream control/status.

---
 rtl/seq_det_pkg.sv | 43 ++++
 rtl/seq_prefix_match.sv | 34 +++
 rtl/seq_det_moore_param.sv | 143 ++++++++++++++
 tb/tb_seq_det_moore_param.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised Moore serial pattern detector:
// default parameters, width helpers and the per-edge action encoding.
package seq_det_pkg;

    // Defaults reproduce the original fixed 0011 detector.
    localparam int          DEFAULT_N       = 4;
    localparam logic [15:0] DEFAULT_PATTERN = 16'b0000_0000_0000_0011;
    localparam int          DEFAULT_CNT_W   = 8;

    // What the detector does with its history on a given clock edge.
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,  // en=0: everything holds
        ACT_LOAD    = 2'd1,  // new pattern loaded, history discarded
        ACT_SAMPLE  = 2'd2,  // w shifted into the history
        ACT_RESTART = 2'd3   // non-overlap after a match: w is the first bit of a fresh history
    } act_e;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

    // Bits needed to hold a state k in 0..n.
    function automatic int state_w(input int n);
        int w;
        w = clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // True when state k denotes a complete match of an n-bit pattern.
    function automatic logic at_full(input int k, input int n);
        return (k == n);
    endfunction

endpackage : seq_det_pkg

// File: rtl/seq_prefix_match.sv
// Combinational prefix/suffix matcher: returns the largest j <= hv such that
// the newest j history bits equal the first j pattern bits.
module seq_prefix_match
    import seq_det_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int KW = state_w(N)
) (
    input  logic [N-1:0]  hist,     // hist[0] is the newest bit
    input  logic [KW-1:0] hv,       // number of valid history bits
    input  logic [N-1:0]  pattern,  // pattern[N-1] is the first bit received
    output logic [KW-1:0] len
);

    // hit[j-1]: the newest j bits are valid and equal the j-bit pattern prefix.
    logic [N-1:0] hit;

    for (genvar j = 1; j <= N; j++) begin : g_cmp
        assign hit[j-1] = (hv >= KW'(j)) && (hist[j-1:0] == pattern[N-1 -: j]);
    end

    // Priority select: later (longer) hits override shorter ones.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path can
        // leave it unassigned and infer a latch.
        len = '0;
        for (int j = 1; j <= N; j++) begin
            if (hit[j-1]) begin
                len = KW'(j);
            end
        end
    end

endmodule : seq_prefix_match

// File: rtl/seq_det_moore_param.sv
// Parametrised Moore serial pattern detector with runtime-loadable pattern,
// selectable overlap, sample enable and a saturating match counter.
// z and state_o are decoded from registered state only.
module seq_det_moore_param
    import seq_det_pkg::*;
#(
    parameter int             N       = DEFAULT_N,
    parameter logic [N-1:0]   PATTERN = N'(DEFAULT_PATTERN),
    parameter int             CNT_W   = DEFAULT_CNT_W
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    en,
    input  logic                    w,
    input  logic                    overlap,
    input  logic                    pat_load,
    input  logic [N-1:0]            pat_in,
    input  logic                    cnt_clr,
    output logic                    z,
    output logic [CNT_W-1:0]        match_cnt,
    output logic [state_w(N)-1:0]   state_o
);

    localparam int              KW      = state_w(N);
    localparam logic [KW-1:0]   K_FULL  = KW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Registered state
    logic [N-1:0]     hist_q,    hist_d;
    logic [KW-1:0]    hv_q,      hv_d;
    logic [KW-1:0]    k_q,       k_d;
    logic [N-1:0]     pattern_q, pattern_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    // Candidate values if this edge samples w
    act_e             act;
    logic [N-1:0]     hist_smp;
    logic [KW-1:0]    hv_smp;
    logic [KW-1:0]    k_smp;
    logic             smp_match;

    // Decode what this edge does: pattern load beats sampling; a match in
    // non-overlap mode restarts the history with the current bit.
    always_comb begin
        act = ACT_HOLD;
        if (pat_load) begin
            act = ACT_LOAD;
        end else if (en) begin
            if (at_full(int'(k_q), N) && !overlap) begin
                act = ACT_RESTART;
            end else begin
                act = ACT_SAMPLE;
            end
        end
    end

    // Shifted history and its valid length; on restart only w is valid, and
    // the older bits are masked off by hv.
    always_comb begin
        hist_smp = {hist_q[N-2:0], w};
        if (act == ACT_RESTART) begin
            hv_smp = KW'(1);
        end else if (hv_q == K_FULL) begin
            hv_smp = hv_q;
        end else begin
            hv_smp = hv_q + KW'(1);
        end
    end

    seq_prefix_match #(
        .N  (N),
        .KW (KW)
    ) u_match (
        .hist    (hist_smp),
        .hv      (hv_smp),
        .pattern (pattern_q),
        .len     (k_smp)
    );

    assign smp_match = at_full(int'(k_smp), N);

    // Next-state selection for history, state and pattern.
    always_comb begin
        hist_d    = hist_q;
        hv_d      = hv_q;
        k_d       = k_q;
        pattern_d = pattern_q;
        unique case (act)
            ACT_LOAD: begin
                pattern_d = pat_in;
                hist_d    = '0;
                hv_d      = '0;
                k_d       = '0;
            end
            ACT_SAMPLE, ACT_RESTART: begin
                hist_d = hist_smp;
                hv_d   = hv_smp;
                k_d    = k_smp;
            end
            default: begin
                // ACT_HOLD: keep everything
            end
        endcase
    end

    // Match counter: clear wins over a same-edge match; saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if ((act == ACT_SAMPLE || act == ACT_RESTART) && smp_match
                     && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!Resetn) begin
            hist_q    <= '0;
            hv_q      <= '0;
            k_q       <= '0;
            pattern_q <= PATTERN;
            cnt_q     <= '0;
        end else begin
            hist_q    <= hist_d;
            hv_q      <= hv_d;
            k_q       <= k_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
        end
    end

    // Moore outputs decoded from registered state only.
    always_comb begin
        z         = at_full(int'(k_q), N);
        state_o   = k_q;
        match_cnt = cnt_q;
    end

endmodule : seq_det_moore_param

// File: tb/tb_seq_det_moore_param.sv
// Self-checking bench for seq_det_moore_param: a behavioural model pushes
// expected outputs into a scoreboard per driven edge; each scenario pops and
// compares after the edge, and also checks hand-derived values.
module tb_seq_det_moore_param;

    logic       clk = 1'b0;
    logic       resetn, en, w, overlap, pat_load, cnt_clr;
    logic [3:0] pat_in;

    logic       z,  z2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [2:0] st, st2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_det_moore_param #(.N(4), .PATTERN(4'b0011), .CNT_W(8)) dut (
        .Clock(clk), .Resetn(resetn), .en(en), .w(w), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .z(z), .match_cnt(cnt8), .state_o(st)
    );

    seq_det_moore_param #(.N(4), .PATTERN(4'b0011), .CNT_W(2)) dut_c2 (
        .Clock(clk), .Resetn(resetn), .en(en), .w(w), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .z(z2), .match_cnt(cnt2), .state_o(st2)
    );

    typedef struct packed {
        logic       z;
        logic [2:0] k;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t sb[$];

    // Model: bits sampled since the last clear, oldest first, at most 4 kept.
    bit         mh[$];
    logic [3:0] mpat;
    int         mk, mc8, mc2;

    function automatic int model_k();
        int sz;
        sz = mh.size();
        for (int j = (sz < 4) ? sz : 4; j >= 1; j--) begin
            bit ok;
            ok = 1'b1;
            for (int i = 0; i < j; i++)
                if (mh[sz - j + i] != mpat[3 - i]) ok = 1'b0;
            if (ok) return j;
        end
        return 0;
    endfunction

    task automatic model_edge(input logic rstn_i, en_i, w_i, ov_i, pl_i,
                              input logic [3:0] pi_i, input logic cc_i);
        exp_t e;
        if (!rstn_i) begin
            mh.delete(); mpat = 4'b0011; mk = 0; mc8 = 0; mc2 = 0;
        end else begin
            if (pl_i) begin
                mpat = pi_i; mh.delete(); mk = 0;
            end else if (en_i) begin
                if (mk == 4 && !ov_i) mh.delete();
                mh.push_back(w_i);
                if (mh.size() > 4) void'(mh.pop_front());
                mk = model_k();
                if (mk == 4) begin
                    if (mc8 < 255) mc8++;
                    if (mc2 < 3)   mc2++;
                end
            end
            if (cc_i) begin mc8 = 0; mc2 = 0; end
        end
        e.z  = (mk == 4);
        e.k  = 3'(mk);
        e.c8 = 8'(mc8);
        e.c2 = 2'(mc2);
        sb.push_back(e);
    endtask

    // Drive one edge: inputs at negedge, model pushes expectation, sample #1 after posedge.
    task automatic cyc(input logic rstn_i, en_i, w_i, ov_i, pl_i,
                       input logic [3:0] pi_i, input logic cc_i);
        @(negedge clk);
        resetn = rstn_i; en = en_i; w = w_i; overlap = ov_i;
        pat_load = pl_i; pat_in = pi_i; cnt_clr = cc_i;
        model_edge(rstn_i, en_i, w_i, ov_i, pl_i, pi_i, cc_i);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 1, 1, 0, 4'b0000, 0);
            e = sb.pop_front(); n_cmp++;
            if ({z, st, cnt8, cnt2, z2, st2} !== {e.z, e.k, e.c8, e.c2, e.z, e.k}) begin
                n_bad++;
                $display("FAIL reset step %0d: got %h want %h", i,
                         {z, st, cnt8, cnt2, z2, st2}, {e.z, e.k, e.c8, e.c2, e.z, e.k});
            end
        end
        n_cmp++;
        if ({z, st, cnt8} !== 12'h000) begin
            n_bad++; $display("FAIL reset_values: got z=%b st=%0d cnt=%0d want 0/0/0", z, st, cnt8);
        end
    endtask

    task automatic test_default();
        logic [3:0] bits;
        int         st_req [4];
        exp_t       e;
        bits   = 4'b0011;
        st_req = '{1, 2, 3, 4};
        cyc(0, 0, 0, 1, 0, 4'b0000, 0); void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, bits[3 - i], 1, 0, 4'b0000, 0);
            e = sb.pop_front(); n_cmp++;
            if ({z, st, cnt8, cnt2, z2, st2} !== {e.z, e.k, e.c8, e.c2, e.z, e.k}) begin
                n_bad++;
                $display("FAIL default step %0d: got %h want %h", i,
                         {z, st, cnt8, cnt2, z2, st2}, {e.z, e.k, e.c8, e.c2, e.z, e.k});
            end
            n_cmp++;
            if (int'(st) != st_req[i] || z !== (i == 3)) begin
                n_bad++; $display("FAIL default_state %0d: got st=%0d z=%b want st=%0d", i, st, z, st_req[i]);
            end
        end
        n_cmp++;
        if (cnt8 !== 8'd1) begin n_bad++; $display("FAIL default_cnt: got %0d want 1", cnt8); end
    endtask

    task automatic test_stream_0101(input logic ov);
        logic [5:0] bits, z_req;
        exp_t       e;
        bits  = 6'b010101;
        z_req = ov ? 6'b000101 : 6'b000100;
        cyc(1, 0, 0, ov, 1, 4'b0101, 1);
        e = sb.pop_front(); n_cmp++;
        if (st !== 3'd0 || cnt8 !== 8'd0) begin
            n_bad++; $display("FAIL load0101_ov%0d: got st=%0d cnt=%0d want 0/0", ov, st, cnt8);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, bits[5 - i], ov, 0, 4'b0000, 0);
            e = sb.pop_front(); n_cmp++;
            if ({z, st, cnt8, cnt2, z2, st2} !== {e.z, e.k, e.c8, e.c2, e.z, e.k}) begin
                n_bad++;
                $display("FAIL stream0101_ov%0d step %0d: got %h want %h", ov, i,
                         {z, st, cnt8, cnt2, z2, st2}, {e.z, e.k, e.c8, e.c2, e.z, e.k});
            end
            n_cmp++;
            if (z !== z_req[5 - i]) begin
                n_bad++; $display("FAIL z0101_ov%0d bit %0d: got %b want %b", ov, i + 1, z, z_req[5 - i]);
            end
            if (!ov && i == 4) begin
                n_cmp++;
                if (st !== 3'd1) begin n_bad++; $display("FAIL nonoverlap_restart: got %0d want 1", st); end
            end
        end
        n_cmp++;
        if (cnt8 !== (ov ? 8'd2 : 8'd1)) begin
            n_bad++; $display("FAIL cnt0101_ov%0d: got %0d want %0d", ov, cnt8, ov ? 2 : 1);
        end
    endtask

    task automatic test_en_hold();
        exp_t e;
        cyc(0, 0, 0, 1, 0, 4'b0000, 0); void'(sb.pop_front());
        for (int i = 0; i < 9; i++) begin
            // 0,0 | en=0 with w 1,0,1 | 1,1 | en=0 with w 0,0
            logic e_i, w_i;
            e_i = (i < 2) || (i == 5) || (i == 6);
            w_i = (i == 2) || (i == 4) || (i == 5) || (i == 6);
            cyc(1, e_i, w_i, 1, 0, 4'b0000, 0);
            e = sb.pop_front(); n_cmp++;
            if ({z, st, cnt8, cnt2, z2, st2} !== {e.z, e.k, e.c8, e.c2, e.z, e.k}) begin
                n_bad++;
                $display("FAIL en_hold step %0d: got %h want %h", i,
                         {z, st, cnt8, cnt2, z2, st2}, {e.z, e.k, e.c8, e.c2, e.z, e.k});
            end
            if (i >= 2 && i <= 4) begin
                n_cmp++;
                if (st !== 3'd2) begin n_bad++; $display("FAIL en_hold_state %0d: got %0d want 2", i, st); end
            end
            if (i >= 6) begin
                n_cmp++;
                if (z !== 1'b1 || cnt8 !== 8'd1) begin
                    n_bad++; $display("FAIL en_hold_match %0d: got z=%b cnt=%0d want 1/1", i, z, cnt8);
                end
            end
        end
    endtask

    task automatic test_pat_load();
        logic [3:0] bits;
        exp_t       e;
        cyc(0, 0, 0, 1, 0, 4'b0000, 0); void'(sb.pop_front());
        bits = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, bits[3 - i], 1, 0, 4'b0000, 0);
            void'(sb.pop_front());
        end
        n_cmp++;
        if (st !== 3'd3) begin n_bad++; $display("FAIL preload_state: got %0d want 3", st); end
        cyc(1, 1, 1, 1, 1, 4'b1110, 0);
        e = sb.pop_front(); n_cmp++;
        if (st !== 3'd0 || z !== 1'b0 || {z, st, cnt8} !== {e.z, e.k, e.c8}) begin
            n_bad++; $display("FAIL pat_load_state: got st=%0d z=%b want 0/0", st, z);
        end
        bits = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, bits[3 - i], 1, 0, 4'b0000, 0);
            e = sb.pop_front(); n_cmp++;
            if ({z, st, cnt8, cnt2, z2, st2} !== {e.z, e.k, e.c8, e.c2, e.z, e.k}) begin
                n_bad++;
                $display("FAIL pat_load step %0d: got %h want %h", i,
                         {z, st, cnt8, cnt2, z2, st2}, {e.z, e.k, e.c8, e.c2, e.z, e.k});
            end
        end
        n_cmp++;
        if (z !== 1'b1 || st !== 3'd4) begin
            n_bad++; $display("FAIL pat1110_match: got z=%b st=%0d want 1/4", z, st);
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        cyc(1, 1, 0, 1, 1, 4'b1111, 1); void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 1, 1, 0, 4'b0000, 0);
            e = sb.pop_front(); n_cmp++;
            if ({z, st, cnt8, cnt2, z2, st2} !== {e.z, e.k, e.c8, e.c2, e.z, e.k}) begin
                n_bad++;
                $display("FAIL saturate step %0d: got %h want %h", i,
                         {z, st, cnt8, cnt2, z2, st2}, {e.z, e.k, e.c8, e.c2, e.z, e.k});
            end
        end
        n_cmp++;
        if (cnt2 !== 2'd3 || cnt8 !== 8'd5) begin
            n_bad++; $display("FAIL saturate_cnt: got cnt2=%0d cnt8=%0d want 3/5", cnt2, cnt8);
        end
        cyc(1, 1, 1, 1, 0, 4'b0000, 1);
        e = sb.pop_front(); n_cmp++;
        if (z !== 1'b1 || cnt2 !== 2'd0 || cnt8 !== 8'd0 || {cnt8, cnt2} !== {e.c8, e.c2}) begin
            n_bad++; $display("FAIL clear_on_match: got z=%b cnt2=%0d cnt8=%0d want 1/0/0", z, cnt2, cnt8);
        end
        cyc(1, 1, 1, 1, 0, 4'b0000, 0);
        e = sb.pop_front(); n_cmp++;
        if (cnt2 !== 2'd1 || cnt8 !== 8'd1 || {cnt8, cnt2} !== {e.c8, e.c2}) begin
            n_bad++; $display("FAIL count_after_clear: got cnt2=%0d cnt8=%0d want 1/1", cnt2, cnt8);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] bits;
        exp_t       e;
        cyc(0, 0, 0, 1, 0, 4'b0000, 0); void'(sb.pop_front());
        bits = 7'b0011001;
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, bits[6 - i], 1, 0, 4'b0000, 0);
            void'(sb.pop_front());
        end
        n_cmp++;
        if (cnt8 !== 8'd1 || st !== 3'd3) begin
            n_bad++; $display("FAIL pre_reset: got cnt=%0d st=%0d want 1/3", cnt8, st);
        end
        cyc(0, 1, 1, 1, 0, 4'b0000, 0);
        e = sb.pop_front(); n_cmp++;
        if (z !== 1'b0 || cnt8 !== 8'd0 || st !== 3'd0 || {z, st, cnt8} !== {e.z, e.k, e.c8}) begin
            n_bad++; $display("FAIL reset_mid_match: got z=%b cnt=%0d st=%0d want 0/0/0", z, cnt8, st);
        end
    endtask

    initial begin
        resetn = 1'b0; en = 1'b0; w = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; pat_in = 4'b0000; cnt_clr = 1'b0;
        test_reset();
        test_default();
        test_stream_0101(1'b1);
        test_stream_0101(1'b0);
        test_en_hold();
        test_pat_load();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seq_det_moore_param
